// File: rtl/rv32i_mem.sv
// RV32I memory-access stage: data-bus handshake, load extension, store lane steering, MEM/WB register.
// Optional misaligned-access trap is enabled by defining RV32I_MEM_MISALIGN_TRAP_EN.
module rv32i_mem #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EX_Mem_wr_en,
  input  logic        EX_Mem_rd_en,
  input  logic [2:0]  EX_Mem_op,
  input  logic        EX_MemToReg,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_Mem_wr_data,
  input  logic        EX_RegFile_wr_en,
  input  logic [4:0]  EX_Rd_addr,
  output logic        D_req,
  output logic        D_we,
  output logic [31:0] D_addr,
  output logic [3:0]  D_be,
  output logic [31:0] D_wdata,
  input  logic        D_ready,
  input  logic [31:0] D_rdata,
  output logic        MEM_Stall,
  output logic [4:0]  MEM_Rd_addr,
  output logic [31:0] MEM_Rd_data,
  output logic        MEM_RegFile_wr_en,
  output logic        MEM_Bus_err,
  output logic        MEM_Misalign_exc
);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              wr_en_q, wr_en_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_q, misalign_d;

  size_t       size;
  logic [1:0]  a;
  logic        mem_op;
  logic        is_store;
  logic        access;
  logic        misalign_evt;
  logic        timeout_now;
  logic        req;
  logic        stall;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  assign a        = EX_ALU_result[1:0];
  assign mem_op   = EX_Mem_rd_en | EX_Mem_wr_en;
  assign is_store = EX_Mem_wr_en & ~EX_Mem_rd_en;

  always_comb begin
    size = SZ_W;
    case (EX_Mem_op)
      3'b000, 3'b100: size = SZ_B;
      3'b001, 3'b101: size = SZ_H;
      default:        size = SZ_W;
    endcase
  end

`ifdef RV32I_MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned   = ((size == SZ_H) & a[0]) | ((size == SZ_W) & (a != 2'b00));
  assign access       = mem_op & ~misaligned;
  assign misalign_evt = mem_op & misaligned;
`else
  // Low address bits are ignored: halfwords use a[1], words are forced aligned.
  assign access       = mem_op;
  assign misalign_evt = 1'b0;
`endif

  assign timeout_now = TIMEOUT_EN && (state_q == S_WAIT) && (cnt_q == TIMEOUT_LIM) && !D_ready;

  // Reset gates the request combinationally so an abandoned access drops at once.
  assign req       = access & ~timeout_now & ~Reset;
  assign stall     = req & ~D_ready;
  assign D_req     = req;
  assign D_we      = req & is_store;
  assign D_addr    = {EX_ALU_result[31:2], 2'b00};
  assign MEM_Stall = stall;

  always_comb begin
    D_be    = 4'b1111;
    D_wdata = EX_Mem_wr_data;
    if (is_store) begin
      case (size)
        SZ_B: begin
          D_be    = 4'b0001 << a;
          D_wdata = {4{EX_Mem_wr_data[7:0]}};
        end
        SZ_H: begin
          D_be    = a[1] ? 4'b1100 : 4'b0011;
          D_wdata = {2{EX_Mem_wr_data[15:0]}};
        end
        default: begin
          D_be    = 4'b1111;
          D_wdata = EX_Mem_wr_data;
        end
      endcase
    end
  end

  always_comb begin
    lane_byte = D_rdata[7:0];
    case (a)
      2'd0: lane_byte = D_rdata[7:0];
      2'd1: lane_byte = D_rdata[15:8];
      2'd2: lane_byte = D_rdata[23:16];
      2'd3: lane_byte = D_rdata[31:24];
      default: lane_byte = D_rdata[7:0];
    endcase
    lane_half = a[1] ? D_rdata[31:16] : D_rdata[15:0];

    load_val = D_rdata;
    case (size)
      SZ_B: load_val = EX_Mem_op[2] ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      SZ_H: load_val = EX_Mem_op[2] ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_val = D_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (access && !D_ready) state_d = S_WAIT;
      S_WAIT: if (!access || D_ready || timeout_now) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
  end

  // Stall, timeout and trap cycles all load a bubble so each instruction writes back once.
  always_comb begin
    rd_addr_d  = EX_Rd_addr;
    rd_data_d  = (access && EX_MemToReg) ? load_val : EX_ALU_result;
    wr_en_d    = EX_RegFile_wr_en & ~is_store & ~stall & ~timeout_now & ~misalign_evt;
    bus_err_d  = timeout_now;
    misalign_d = misalign_evt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      wr_en_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      wr_en_q    <= wr_en_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign MEM_Rd_addr       = rd_addr_q;
  assign MEM_Rd_data       = rd_data_q;
  assign MEM_RegFile_wr_en = wr_en_q;
  assign MEM_Bus_err       = bus_err_q;
  assign MEM_Misalign_exc  = misalign_q;

endmodule

// File: tb/tb_rv32i_mem.sv
// Self-checking bench for rv32i_mem: scoreboard of expected MEM/WB results plus inline bus checks.
module tb_rv32i_mem;
  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en;
  logic [2:0]  EX_Mem_op;
  logic [31:0] EX_ALU_result, EX_Mem_wr_data;
  logic [4:0]  EX_Rd_addr;
  logic        D_req, D_we, D_ready;
  logic [31:0] D_addr, D_wdata, D_rdata;
  logic [3:0]  D_be;
  logic        MEM_Stall, MEM_RegFile_wr_en, MEM_Bus_err, MEM_Misalign_exc;
  logic [4:0]  MEM_Rd_addr;
  logic [31:0] MEM_Rd_data;

  rv32i_mem #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_op(EX_Mem_op),
    .EX_MemToReg(EX_MemToReg), .EX_ALU_result(EX_ALU_result), .EX_Mem_wr_data(EX_Mem_wr_data),
    .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
    .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_be(D_be), .D_wdata(D_wdata),
    .D_ready(D_ready), .D_rdata(D_rdata),
    .MEM_Stall(MEM_Stall), .MEM_Rd_addr(MEM_Rd_addr), .MEM_Rd_data(MEM_Rd_data),
    .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_Bus_err(MEM_Bus_err), .MEM_Misalign_exc(MEM_Misalign_exc)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {logic [4:0] rd; logic [31:0] data; logic we;} wb_t;
  wb_t sb_q[$];
  wb_t e;
  int  n_checks = 0;
  int  n_pass   = 0;

  localparam logic [2:0]  LD_OP   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b111};
  localparam logic [31:0] LD_ADDR [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101, 32'h100};
  localparam logic [31:0] LD_RDATA[8] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                                          32'h80FF_0000, 32'h1234_567F, 32'h1234_A57F, 32'hDEAD_BEEF};
  localparam logic [31:0] LD_EXP  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                          32'h80FF_0000, 32'h0000_007F, 32'h0000_00A5, 32'hDEAD_BEEF};

  task automatic drive_ex(input logic rd_en, input logic wr_en, input logic [2:0] op, input logic m2r,
                          input logic [31:0] addr, input logic [31:0] wd, input logic rfwe,
                          input logic [4:0] rd);
    EX_Mem_rd_en = rd_en; EX_Mem_wr_en = wr_en; EX_Mem_op = op; EX_MemToReg = m2r;
    EX_ALU_result = addr; EX_Mem_wr_data = wd; EX_RegFile_wr_en = rfwe; EX_Rd_addr = rd;
  endtask

  task automatic drive_nop(input logic [31:0] alu, input logic [4:0] rd);
    drive_ex(1'b0, 1'b0, 3'b010, 1'b0, alu, 32'd0, 1'b1, rd);
  endtask

  task automatic test_reset;
    Reset = 1'b1; D_ready = 1'b0; D_rdata = 32'd0;
    drive_ex(1'b1, 1'b0, 3'b010, 1'b1, 32'h40, 32'd0, 1'b1, 5'd3);
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({D_req, D_we, MEM_Stall} !== 3'b000)
      $display("FAIL reset_bus: got req/we/stall=%b want 000", {D_req, D_we, MEM_Stall});
    else n_pass++;
    n_checks++;
    if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, MEM_Bus_err, MEM_Misalign_exc} !== 40'd0)
      $display("FAIL reset_wb: got rd=%0d data=%h we=%b err=%b exc=%b want all 0",
               MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, MEM_Bus_err, MEM_Misalign_exc);
    else n_pass++;
    drive_nop(32'd0, 5'd0);
    Reset = 1'b0;
  endtask

  task automatic test_alu;
    @(negedge Clk);
    drive_nop(32'h0000_1234, 5'd5);
    sb_q.push_back('{5'd5, 32'h0000_1234, 1'b1});
    #1;
    n_checks++;
    if ({D_req, MEM_Stall} !== 2'b00) $display("FAIL alu_noreq: got req/stall=%b want 00", {D_req, MEM_Stall});
    else n_pass++;
    @(negedge Clk);
    drive_ex(1'b0, 1'b0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd31);
    e = sb_q.pop_front();
    n_checks++;
    if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
      $display("FAIL alu_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
               MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
    else n_pass++;
    sb_q.push_back('{5'd31, 32'hFFFF_FFFF, 1'b0});
    @(negedge Clk);
    e = sb_q.pop_front();
    n_checks++;
    if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
      $display("FAIL alu_nowr_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
               MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
    else n_pass++;
  endtask

  task automatic test_load;
    @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      drive_ex(1'b1, 1'b0, LD_OP[i], 1'b1, LD_ADDR[i], 32'd0, 1'b1, 5'(i + 1));
      D_ready = 1'b1; D_rdata = LD_RDATA[i];
      sb_q.push_back('{5'(i + 1), LD_EXP[i], 1'b1});
      #1;
      n_checks++;
      if ({D_req, D_we, D_be, D_addr, MEM_Stall} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0})
        $display("FAIL load%0d_bus: got req=%b we=%b be=%b addr=%h stall=%b want 1 0 1111 00000100 0",
                 i, D_req, D_we, D_be, D_addr, MEM_Stall);
      else n_pass++;
      @(negedge Clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
        $display("FAIL load%0d_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
                 i, MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
      else n_pass++;
    end
    drive_nop(32'd0, 5'd0); D_ready = 1'b0;
  endtask

  task automatic test_store;
    logic [31:0] st_addr [3] = '{32'h201, 32'h20C, 32'h203};
    logic [2:0]  st_op   [3] = '{3'b000, 3'b010, 3'b000};
    logic [31:0] st_wd   [3] = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0000_00AB};
    logic [3:0]  st_be   [3] = '{4'b0010, 4'b1111, 4'b1000};
    logic [31:0] st_lane [3] = '{32'h7878_7878, 32'hCAFE_F00D, 32'hABAB_ABAB};
    logic [31:0] st_da   [3] = '{32'h200, 32'h20C, 32'h200};
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b0, 1'b1, st_op[i], 1'b0, st_addr[i], st_wd[i], 1'b1, 5'd4);
      D_ready = 1'b1;
      sb_q.push_back('{5'd4, st_addr[i], 1'b0});
      #1;
      n_checks++;
      if ({D_req, D_we, D_be, D_wdata, D_addr, MEM_Stall} !== {1'b1, 1'b1, st_be[i], st_lane[i], st_da[i], 1'b0})
        $display("FAIL store%0d_bus: got req=%b we=%b be=%b wdata=%h addr=%h stall=%b want be=%b wdata=%h addr=%h",
                 i, D_req, D_we, D_be, D_wdata, D_addr, MEM_Stall, st_be[i], st_lane[i], st_da[i]);
      else n_pass++;
      @(negedge Clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
        $display("FAIL store%0d_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
                 i, MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
      else n_pass++;
    end
    // An ALU result with wr_en=1 precedes the waited store so the bubble is observable.
    drive_nop(32'h777, 5'd3); D_ready = 1'b0;
    @(negedge Clk);
    drive_ex(1'b0, 1'b1, 3'b001, 1'b0, 32'h202, 32'h0000_BEEF, 1'b1, 5'd9);
    #1;
    n_checks++;
    if ({D_req, D_we, D_be, D_wdata, D_addr, MEM_Stall} !== {1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h200, 1'b1})
      $display("FAIL sh_bus: got req=%b we=%b be=%b wdata=%h addr=%h stall=%b want 1 1 1100 beefbeef 00000200 1",
               D_req, D_we, D_be, D_wdata, D_addr, MEM_Stall);
    else n_pass++;
    for (int k = 1; k < 3; k++) begin
      @(negedge Clk); #1;
      n_checks++;
      if ({MEM_Stall, D_req, D_we, D_be, D_wdata, D_addr, MEM_RegFile_wr_en} !==
          {1'b1, 1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h200, 1'b0})
        $display("FAIL sh_wait%0d: got stall=%b req=%b be=%b wdata=%h addr=%h wbwe=%b want stall=1 stable bus wbwe=0",
                 k, MEM_Stall, D_req, D_be, D_wdata, D_addr, MEM_RegFile_wr_en);
      else n_pass++;
    end
    @(negedge Clk);
    D_ready = 1'b1;
    sb_q.push_back('{5'd9, 32'h202, 1'b0});
    #1;
    n_checks++;
    if (MEM_Stall !== 1'b0) $display("FAIL sh_done_stall: got %b want 0", MEM_Stall);
    else n_pass++;
    @(negedge Clk);
    e = sb_q.pop_front();
    n_checks++;
    if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
      $display("FAIL sh_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
               MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
    else n_pass++;
    drive_nop(32'd0, 5'd0); D_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    @(negedge Clk);
    drive_nop(32'h55, 5'd2);
    @(negedge Clk);
    drive_ex(1'b1, 1'b0, 3'b010, 1'b1, 32'h400, 32'd0, 1'b1, 5'd10);
    D_ready = 1'b0;
    n = 0;
    #1;
    while (MEM_Stall === 1'b1 && n < 20) begin
      n++;
      @(negedge Clk); #1;
    end
    // Request cycle in IDLE plus TO wait cycles before the abort.
    n_checks++;
    if (n !== TO + 1) $display("FAIL to_stall_len: got %0d cycles want %0d", n, TO + 1);
    else n_pass++;
    n_checks++;
    if ({D_req, MEM_Bus_err, MEM_RegFile_wr_en} !== 3'b000)
      $display("FAIL to_abort: got req=%b err=%b wbwe=%b want 000", D_req, MEM_Bus_err, MEM_RegFile_wr_en);
    else n_pass++;
    @(negedge Clk); #1;
    n_checks++;
    if ({MEM_Bus_err, MEM_RegFile_wr_en} !== 2'b10)
      $display("FAIL to_err_pulse: got err=%b wbwe=%b want 1 0", MEM_Bus_err, MEM_RegFile_wr_en);
    else n_pass++;
    drive_nop(32'h99, 5'd11);
    sb_q.push_back('{5'd11, 32'h99, 1'b1});
    #1;
    n_checks++;
    if ({D_req, MEM_Stall} !== 2'b00) $display("FAIL to_idle: got req/stall=%b want 00", {D_req, MEM_Stall});
    else n_pass++;
    @(negedge Clk); #1;
    n_checks++;
    if (MEM_Bus_err !== 1'b0) $display("FAIL to_err_once: got %b want 0", MEM_Bus_err);
    else n_pass++;
    e = sb_q.pop_front();
    n_checks++;
    if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
      $display("FAIL to_after_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
               MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge Clk);
    drive_ex(1'b0, 1'b1, 3'b010, 1'b0, 32'h500, 32'h1111_2222, 1'b1, 5'd12);
    D_ready = 1'b0;
    @(negedge Clk); #1;
    n_checks++;
    if ({D_req, MEM_Stall} !== 2'b11) $display("FAIL rst_mid_wait: got req/stall=%b want 11", {D_req, MEM_Stall});
    else n_pass++;
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({D_req, D_we, MEM_Stall, MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, MEM_Bus_err, MEM_Misalign_exc} !== 43'd0)
      $display("FAIL rst_mid_async: got req=%b stall=%b rd=%0d data=%h we=%b want all 0",
               D_req, MEM_Stall, MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en);
    else n_pass++;
    @(negedge Clk);
    drive_nop(32'h4321, 5'd6);
    Reset = 1'b0;
    sb_q.push_back('{5'd6, 32'h4321, 1'b1});
    @(negedge Clk);
    e = sb_q.pop_front();
    n_checks++;
    if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
      $display("FAIL rst_mid_after_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
               MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
    else n_pass++;
  endtask

  task automatic test_misalign;
    logic [2:0]  m_op  [2] = '{3'b010, 3'b001};
    logic [31:0] m_adr [2] = '{32'h301, 32'h303};
    logic [31:0] m_exp [2] = '{32'hDEAD_BEEF, 32'hFFFF_DEAD};
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      drive_ex(1'b1, 1'b0, m_op[i], 1'b1, m_adr[i], 32'd0, 1'b1, 5'd13);
      D_ready = 1'b1; D_rdata = 32'hDEAD_BEEF;
`ifdef RV32I_MEM_MISALIGN_TRAP_EN
      #1;
      n_checks++;
      if ({D_req, MEM_Stall} !== 2'b00) $display("FAIL mis%0d_noreq: got req/stall=%b want 00", i, {D_req, MEM_Stall});
      else n_pass++;
      @(negedge Clk);
      n_checks++;
      if ({MEM_Misalign_exc, MEM_RegFile_wr_en} !== 2'b10)
        $display("FAIL mis%0d_exc: got exc=%b wbwe=%b want 1 0", i, MEM_Misalign_exc, MEM_RegFile_wr_en);
      else n_pass++;
      drive_nop(32'h1, 5'd14);
      @(negedge Clk);
      n_checks++;
      if (MEM_Misalign_exc !== 1'b0) $display("FAIL mis%0d_exc_once: got %b want 0", i, MEM_Misalign_exc);
      else n_pass++;
`else
      sb_q.push_back('{5'd13, m_exp[i], 1'b1});
      #1;
      n_checks++;
      if ({D_req, D_addr, MEM_Stall} !== {1'b1, 32'h300, 1'b0})
        $display("FAIL mis%0d_bus: got req=%b addr=%h stall=%b want 1 00000300 0", i, D_req, D_addr, MEM_Stall);
      else n_pass++;
      @(negedge Clk);
      e = sb_q.pop_front();
      n_checks++;
      if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, MEM_Misalign_exc} !== {e, 1'b0})
        $display("FAIL mis%0d_wb: got rd=%0d data=%h we=%b exc=%b want rd=%0d data=%h we=%b exc=0",
                 i, MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, MEM_Misalign_exc, e.rd, e.data, e.we);
      else n_pass++;
`endif
    end
    drive_nop(32'd0, 5'd0); D_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] v, ad;
    logic [4:0]  r;
    @(negedge Clk);
    for (int i = 0; i < 12; i++) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
          $display("FAIL b2b%0d_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
                   i, MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
        else n_pass++;
      end
      v = $urandom;
      r = 5'($urandom_range(1, 31));
      if (i % 2 == 0) begin
        drive_nop(v, r); D_ready = 1'b0;
      end else begin
        ad = $urandom;
        ad[1:0] = 2'b00;
        drive_ex(1'b1, 1'b0, 3'b010, 1'b1, ad, 32'd0, 1'b1, r);
        D_ready = 1'b1; D_rdata = v;
      end
      sb_q.push_back('{r, v, 1'b1});
      @(negedge Clk);
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en} !== e)
      $display("FAIL b2b_last_wb: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
               MEM_Rd_addr, MEM_Rd_data, MEM_RegFile_wr_en, e.rd, e.data, e.we);
    else n_pass++;
    drive_nop(32'd0, 5'd0); D_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
